input_debouncer: RTL and testbench

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

---
 rtl/input_debouncer_pkg.sv | 18 +
 rtl/input_debouncer_channel.sv | 61 ++++++
 rtl/input_debouncer.sv | 29 ++
 tb/tb_input_debouncer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/input_debouncer_pkg.sv
// Shared constants and helpers for the input debouncer.
package input_debouncer_pkg;

    localparam int unsigned STABLE_CYCLES_DEFAULT = 4;

    // Bits needed to count 0..value-1, never less than one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        bits = 1;
        for (int unsigned b = 1; b < 32; b++) begin
            if ((64'd1 << b) < 64'(value)) begin
                bits = b + 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/input_debouncer_channel.sv
// One debounced channel: two-flop synchronizer, stability counter, edge pulses.
module debounce_channel
    import input_debouncer_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
    input  logic CLK,
    input  logic RESET,
    input  logic i,
    output logic o,
    output logic rise,
    output logic fall
);

    localparam int unsigned CNT_W = clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1;
    logic             s;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             o_next;
    logic             rise_next;
    logic             fall_next;

    // A differing level must survive STABLE_CYCLES samples; any match restarts.
    always_comb begin
        cnt_next  = '0;
        o_next    = o;
        rise_next = 1'b0;
        fall_next = 1'b0;
        if (s != o) begin
            if (cnt == CNT_LAST) begin
                o_next    = s;
                rise_next = s;
                fall_next = ~s;
            end else begin
                cnt_next = CNT_W'(cnt + 1'b1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            cnt   <= '0;
            o     <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= i;
            s     <= sync1;
            cnt   <= cnt_next;
            o     <= o_next;
            rise  <= rise_next;
            fall  <= fall_next;
        end
    end

endmodule

// File: rtl/input_debouncer.sv
// Multi-channel debouncer: WIDTH independent debounce_channel instances.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int unsigned WIDTH         = 2,
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] O,
    output logic [WIDTH-1:0] RISE,
    output logic [WIDTH-1:0] FALL
);

    for (genvar n = 0; n < WIDTH; n++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_ch (
            .CLK  (CLK),
            .RESET(RESET),
            .i    (I[n]),
            .o    (O[n]),
            .rise (RISE[n]),
            .fall (FALL[n])
        );
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer (WIDTH=2, STABLE_CYCLES=4).
module tb_input_debouncer;

    localparam int unsigned W  = 2;
    localparam int unsigned ST = 4;

    logic         CLK;
    logic         RESET;
    logic [W-1:0] I;
    logic [W-1:0] O;
    logic [W-1:0] RISE;
    logic [W-1:0] FALL;

    input_debouncer #(.WIDTH(W), .STABLE_CYCLES(ST)) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .I    (I),
        .O    (O),
        .RISE (RISE),
        .FALL (FALL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int pass_cnt = 0;
    int total    = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // Reference: a level is accepted once the last ST synchronized samples
    // seen since the previous acceptance all disagree with the output.
    logic [W-1:0]  m_sync1, m_sync2, m_o, m_rise, m_fall;
    logic [ST-1:0] win [W];
    int unsigned   seen [W];

    task automatic model_reset();
        m_sync1 = '0; m_sync2 = '0; m_o = '0; m_rise = '0; m_fall = '0;
        for (int n = 0; n < W; n++) begin
            win[n]  = '0;
            seen[n] = 0;
        end
    endtask

    task automatic model_edge();
        logic s;
        for (int n = 0; n < W; n++) begin
            s         = m_sync2[n];
            win[n]    = {win[n][ST-2:0], s};
            seen[n]   = (seen[n] < ST) ? seen[n] + 1 : ST;
            m_rise[n] = 1'b0;
            m_fall[n] = 1'b0;
            if (seen[n] >= ST && win[n] == {ST{~m_o[n]}}) begin
                m_rise[n] = ~m_o[n];
                m_fall[n] = m_o[n];
                m_o[n]    = ~m_o[n];
                seen[n]   = 0;
            end
        end
        m_sync2 = m_sync1;
        m_sync1 = I;
    endtask

    // One clock: model advances on the edge, DUT compared on the falling edge.
    task automatic tick();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check("model_o", O, m_o);
        check("model_rise", RISE, m_rise);
        check("model_fall", FALL, m_fall);
        check("rise_fall_excl", RISE & FALL, '0);
    endtask

    typedef struct {
        logic [W-1:0] i;
        logic [W-1:0] o;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [W-1:0] i, input int n, input logic [W-1:0] o,
                                input logic [W-1:0] r, input logic [W-1:0] f);
        vec_t v;
        v.i = i; v.o = o; v.rise = r; v.fall = f;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endfunction

    int           hold [W];
    logic [W-1:0] o_ref;

    initial begin
        RESET = 1'b1;
        I     = '0;
        model_reset();
        #1;
        check("reset_o", O, '0);
        check("reset_rise", RISE, '0);
        check("reset_fall", FALL, '0);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;

        // Quiet input after reset
        for (int c = 0; c < 20; c++) begin
            tick();
            check("idle_o", O, 2'b00);
            check("idle_pulses", RISE | FALL, 2'b00);
        end

        // Edge-exact table: single accept, release, glitch, re-accept, both channels
        add(2'b01, 5, 2'b00, 2'b00, 2'b00);
        add(2'b01, 1, 2'b01, 2'b01, 2'b00);
        add(2'b01, 1, 2'b01, 2'b00, 2'b00);
        add(2'b00, 5, 2'b01, 2'b00, 2'b00);
        add(2'b00, 1, 2'b00, 2'b00, 2'b01);
        add(2'b00, 2, 2'b00, 2'b00, 2'b00);
        add(2'b01, 3, 2'b00, 2'b00, 2'b00);
        add(2'b00, 6, 2'b00, 2'b00, 2'b00);
        add(2'b01, 5, 2'b00, 2'b00, 2'b00);
        add(2'b01, 1, 2'b01, 2'b01, 2'b00);
        add(2'b00, 5, 2'b01, 2'b00, 2'b00);
        add(2'b00, 1, 2'b00, 2'b00, 2'b01);
        add(2'b00, 2, 2'b00, 2'b00, 2'b00);
        add(2'b11, 5, 2'b00, 2'b00, 2'b00);
        add(2'b11, 1, 2'b11, 2'b11, 2'b00);
        add(2'b11, 2, 2'b11, 2'b00, 2'b00);
        foreach (tbl[k]) begin
            I = tbl[k].i;
            tick();
            check($sformatf("tbl_o[%0d]", k), O, tbl[k].o);
            check($sformatf("tbl_rise[%0d]", k), RISE, tbl[k].rise);
            check($sformatf("tbl_fall[%0d]", k), FALL, tbl[k].fall);
        end

        // Reset mid-count clears O immediately without a FALL pulse
        I = 2'b00;
        tick();
        tick();
        RESET = 1'b1;
        model_reset();
        #1;
        check("midrst_o", O, 2'b00);
        check("midrst_fall", FALL, 2'b00);
        check("midrst_rise", RISE, 2'b00);
        @(negedge CLK);
        RESET = 1'b0;
        I = 2'b11;
        for (int e = 0; e < 5; e++) begin
            tick();
            check("postrst_wait_o", O, 2'b00);
            check("postrst_wait_rise", RISE, 2'b00);
        end
        tick();
        check("postrst_o", O, 2'b11);
        check("postrst_rise", RISE, 2'b11);

        // Chatter shorter than the stability window must never be accepted
        o_ref = m_o;
        for (int n = 0; n < W; n++) hold[n] = $urandom_range(1, 3);
        for (int c = 0; c < 200; c++) begin
            for (int n = 0; n < W; n++) begin
                hold[n]--;
                if (hold[n] == 0) begin
                    I[n]    = ~I[n];
                    hold[n] = $urandom_range(1, 3);
                end
            end
            tick();
            check("chatter_o", O, o_ref);
        end

        // Longer random holds exercise accepts on independent schedules
        for (int n = 0; n < W; n++) hold[n] = $urandom_range(1, 8);
        for (int c = 0; c < 400; c++) begin
            for (int n = 0; n < W; n++) begin
                hold[n]--;
                if (hold[n] == 0) begin
                    I[n]    = ~I[n];
                    hold[n] = $urandom_range(1, 8);
                end
            end
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
